adc_sample_framer: RTL and testbench
====================================

// Module: adc_sample_framer
// PURPOSE
//  Consumes the modular ADC response stream, keeps one selected channel and converts
//  offset-binary codes to signed two's complement. Buffers samples in a circular RAM and
//  emits overlapping windows of WINDOW_LEN samples every HOP samples as a packetised
//  valid/ready stream. Sits between the ADC Qsys subsystem and the 1D-CNN input layer.
// PARAMETERS
//  DATA_W     12   ADC code width
//  CH_W       5    ADC channel field width
//  CHANNEL    1    channel number accepted; all others ignored
//  OUT_W      16   output sample width (signed); must be >= DATA_W
//  WINDOW_LEN 64   samples per emitted window (>=2)
//  HOP        32   new samples between window starts (1..WINDOW_LEN)
//  BUF_DEPTH  128  RAM depth; power of two, >= WINDOW_LEN+HOP
// PORTS
//  clk            in   1       system clock (ADC response clock domain)
//  reset_n        in   1       synchronous active-low reset
//  enable         in   1       1: accept samples; 0: ignore input, finish current window
//  adc_valid      in   1       response valid (no backpressure on this side)
//  adc_channel    in   CH_W    response channel
//  adc_data       in   DATA_W  response code, offset binary
//  out_valid      out  1       output beat valid
//  out_ready      in   1       downstream ready
//  out_data       out  OUT_W   signed sample
//  out_sop        out  1       first beat of window
//  out_eop        out  1       last beat of window
//  overrun        out  1       sticky: a sample or a window trigger was dropped
//  clear_overrun  in   1       clears overrun (set wins if same cycle)
// BEHAVIOUR
//  - Reset: out_valid/out_sop/out_eop/overrun = 0, out_data = 0, pointers/counters = 0, state FILL.
//  - Accept = adc_valid & enable & (adc_channel==CHANNEL). Stored = {~adc_data[MSB], adc_data[MSB-1:0]}
//    sign-extended to OUT_W (code 0 -> -2048, 2048 -> 0, 4095 -> 2047).
//  - wr_ptr (log2 BUF_DEPTH bits, wraps) advances per stored sample; hop_cnt counts stored samples.
//  - States: FILL -> IDLE on WINDOW_LEN-th stored sample (this is trigger 0; hop_cnt reset).
//    IDLE: trigger when hop_cnt reaches HOP. EMIT: stream WINDOW_LEN beats.
//    Trigger latches win_base = wr_ptr after write - WINDOW_LEN (mod BUF_DEPTH), i.e. window ends at
//    the triggering sample; IDLE->EMIT on trigger.
//  - Trigger during EMIT: stored in 1-deep pending slot (its own base). Trigger while pending full:
//    discarded, overrun set.
//  - EMIT: rd_ptr from win_base; RAM read latency 1; out_data/out_sop/out_eop registered; beats
//    transfer on out_valid&out_ready. While stalled out_data/sop/eop/valid hold. out_valid never
//    drops mid-window. On eop handshake: pending -> EMIT again (first beat valid <=2 cycles later),
//    else IDLE.
//  - Protection: in EMIT (or pending set), accepted sample dropped (not written, wr_ptr and hop_cnt
//    unchanged) when wr_ptr - win_base == BUF_DEPTH; overrun set. Emitted windows never corrupted.
//  - Simultaneous write and read in the same cycle are to distinct addresses; no bypass needed.
//  - enable=0: inputs ignored, counters frozen; in-flight and pending windows still emitted.
//  - reset_n low mid-operation: next cycle all outputs at reset values, pending lost, refill required.
// STRUCTURE
//  - adc_pkg.sv: framer state enum (FILL, IDLE, EMIT), offset-to-signed conversion function,
//    ADC width constants shared with the command sequencer.
//  - Sub-module sdp_ram (simple dual-port, registered read, BUF_DEPTH x OUT_W) so it maps to M9K;
//    control/pointers/output register stay in adc_sample_framer.
// TESTING (WINDOW_LEN=8, HOP=4, BUF_DEPTH=16, CHANNEL=1, out_ready=1 unless stated)
//  1. Ramp codes 2048+i, i=0..15 -> window0 = 0..7 (sop on 0, eop on 7), window1 = 4..11, window2 = 8..15.
//  2. Interleave ch1 ramp with ch0/ch2 codes 4095 -> output identical to test 1, no 2047 values.
//  3. Codes 0, 2048, 4095 among 8 samples -> out_data 16'hF800, 16'h0000, 16'h07FF at those beats.
//  4. Test 1 with out_ready random 30% low -> same beat sequence, data/sop/eop stable while stalled.
//  5. out_ready=0 after FILL, feed 20 samples -> samples 16..19 dropped, overrun=1; trigger during
//     pending-full sets overrun; release -> window 0..7 intact, then 4..11; clear_overrun -> 0.
//  6. reset_n low at beat 3 of window0 -> out_valid=0 next cycle, overrun=0, no output until 8 new samples.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared ADC constants, framer state encoding and offset-binary conversion used by the
// sample framer and the command sequencer.
package adc_pkg;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_CH_W   = 5;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_IDLE,
    ST_EMIT
  } framer_state_e;

  // Flip the code MSB, then sign-extend from that bit: 0 -> most negative, mid-scale -> 0.
  function automatic logic [31:0] offset_to_signed(input logic [31:0] code, input int data_w);
    logic [31:0] mask;
    logic [31:0] msb;
    logic [31:0] flipped;
    mask    = (32'd1 << data_w) - 32'd1;
    msb     = 32'd1 << (data_w - 1);
    flipped = (code & mask) ^ msb;
    if ((flipped & msb) != 32'd0) begin
      offset_to_signed = flipped | ~mask;
    end else begin
      offset_to_signed = flipped;
    end
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM with a registered, enable-gated read port (holds its output
// while no read is issued), shaped to map onto a single block RAM.
module sdp_ram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/adc_sample_framer.sv
// Selects one ADC channel, converts to signed samples, buffers them in a circular RAM
// and streams overlapping WINDOW_LEN-sample windows every HOP samples.
module adc_sample_framer
  import adc_pkg::*;
#(
  parameter int DATA_W     = ADC_DATA_W,
  parameter int CH_W       = ADC_CH_W,
  parameter int CHANNEL    = 1,
  parameter int OUT_W      = 16,
  parameter int WINDOW_LEN = 64,
  parameter int HOP        = 32,
  parameter int BUF_DEPTH  = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              adc_valid,
  input  logic [CH_W-1:0]   adc_channel,
  input  logic [DATA_W-1:0] adc_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              overrun,
  input  logic              clear_overrun
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(WINDOW_LEN + 1);

  framer_state_e    r_state;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_win_base;
  logic [PW-1:0]    r_pend_base;
  logic             r_pend_vld;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_rd_left;
  logic             r_q_vld;
  logic             r_q_sop;
  logic             r_q_eop;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_sop;
  logic             r_out_eop;
  logic             r_overrun;

  logic [OUT_W-1:0] w_sample;
  logic [OUT_W-1:0] w_ram_q;
  logic             w_accept;
  logic             w_full;
  logic             w_store;
  logic             w_drop;
  logic [PW-1:0]    w_wr_next;
  logic [PW-1:0]    w_trig_base;
  logic [PW-1:0]    w_start_base;
  logic             w_trig;
  logic             w_trig_lost;
  logic             w_out_fire;
  logic             w_eop_fire;
  logic             w_q_take;
  logic             w_rd_en;
  logic             w_start;

  assign w_sample    = OUT_W'(offset_to_signed(32'(adc_data), DATA_W));
  assign w_accept    = adc_valid & enable & (adc_channel == CH_W'(CHANNEL));
  // Pointers carry one extra bit so a completely full buffer is distinguishable from empty.
  assign w_full      = (r_state == ST_EMIT) && ((r_wr_ptr - r_win_base) == PW'(BUF_DEPTH));
  assign w_store     = w_accept & ~w_full;
  assign w_drop      = w_accept & w_full;
  assign w_wr_next   = r_wr_ptr + 1'b1;
  assign w_trig_base = w_wr_next - PW'(WINDOW_LEN);
  assign w_trig      = w_store && ((r_state == ST_FILL) ? (r_cnt == CW'(WINDOW_LEN - 1))
                                                        : (r_cnt == CW'(HOP - 1)));
  assign w_out_fire  = r_out_valid & out_ready;
  assign w_eop_fire  = w_out_fire & r_out_eop;
  assign w_trig_lost = (r_state == ST_EMIT) & w_trig & ~w_eop_fire & r_pend_vld;
  assign w_start     = ((r_state != ST_EMIT) && w_trig) ||
                       ((r_state == ST_EMIT) && w_eop_fire && (r_pend_vld || w_trig));
  assign w_start_base = ((r_state == ST_EMIT) && r_pend_vld) ? r_pend_base : w_trig_base;
  // The RAM output register acts as a second pipeline stage so stalls never lose a beat.
  assign w_q_take    = r_q_vld & (~r_out_valid | out_ready);
  assign w_rd_en     = (r_rd_left != '0) & (~r_q_vld | w_q_take);

  sdp_ram #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (OUT_W),
    .AW    (AW)
  ) u_ram (
    .i_clk     (clk),
    .i_wr_en   (w_store),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (w_sample),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_FILL;
      r_wr_ptr    <= '0;
      r_win_base  <= '0;
      r_pend_base <= '0;
      r_pend_vld  <= 1'b0;
      r_cnt       <= '0;
      r_rd_ptr    <= '0;
      r_rd_left   <= '0;
      r_q_vld     <= 1'b0;
      r_q_sop     <= 1'b0;
      r_q_eop     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= w_wr_next;
        r_cnt    <= w_trig ? '0 : r_cnt + 1'b1;
      end

      if (w_rd_en) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_left <= r_rd_left - 1'b1;
        r_q_sop   <= (r_rd_left == CW'(WINDOW_LEN));
        r_q_eop   <= (r_rd_left == CW'(1));
        r_q_vld   <= 1'b1;
      end else if (w_q_take) begin
        r_q_vld <= 1'b0;
      end

      if (w_start) begin
        r_state    <= ST_EMIT;
        r_win_base <= w_start_base;
        r_rd_ptr   <= w_start_base[AW-1:0];
        r_rd_left  <= CW'(WINDOW_LEN);
      end else if (w_eop_fire) begin
        r_state <= ST_IDLE;
      end

      // A trigger arriving as the pending window launches refills the slot in the same cycle.
      if ((r_state == ST_EMIT) && w_trig && !w_eop_fire) begin
        if (!r_pend_vld) begin
          r_pend_vld  <= 1'b1;
          r_pend_base <= w_trig_base;
        end
      end else if ((r_state == ST_EMIT) && w_eop_fire && r_pend_vld) begin
        if (w_trig) begin
          r_pend_base <= w_trig_base;
        end else begin
          r_pend_vld <= 1'b0;
        end
      end

      r_overrun <= (r_overrun & ~clear_overrun) | w_drop | w_trig_lost;

      if (w_q_take) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ram_q;
        r_out_sop   <= r_q_sop;
        r_out_eop   <= r_q_eop;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_out_sop   <= 1'b0;
        r_out_eop   <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sop   = r_out_sop;
  assign out_eop   = r_out_eop;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_adc_sample_framer.sv
// Directed bench for adc_sample_framer with an 8-sample window, hop of 4 and 16-deep buffer.
module tb_adc_sample_framer;

  localparam int WinLen = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        adc_valid = 1'b0;
  logic [4:0]  adc_channel = 5'd0;
  logic [11:0] adc_data = 12'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        overrun;
  logic        clear_overrun = 1'b0;

  int          totalCount = 0;
  int          badCount = 0;
  logic [17:0] expQ[$];
  logic        monEn = 1'b0;
  logic        randomReady = 1'b0;
  logic [15:0] sampleVal [32];

  logic [11:0] t3Code [8] = '{12'd0, 12'd2048, 12'd4095, 12'd100,
                              12'd3000, 12'd2047, 12'd2049, 12'd1};
  logic [15:0] t3Exp [8]  = '{16'hF800, 16'h0000, 16'h07FF, 16'hF864,
                              16'h03B8, 16'hFFFF, 16'h0001, 16'hF801};

  always #5 clk = ~clk;

  adc_sample_framer #(
    .DATA_W     (12),
    .CH_W       (5),
    .CHANNEL    (1),
    .OUT_W      (16),
    .WINDOW_LEN (WinLen),
    .HOP        (4),
    .BUF_DEPTH  (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .adc_valid     (adc_valid),
    .adc_channel   (adc_channel),
    .adc_data      (adc_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
    end
  endtask

  // Every presented beat must match the head of the expected queue, stalled or not.
  always @(negedge clk) begin
    if (monEn && reset_n && out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("extra_beat", 32'(out_valid), 32'd0);
      end else begin
        checkOutput("beat", {14'd0, out_sop, out_eop, out_data}, {14'd0, expQ[0]});
        if (out_ready) void'(expQ.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (randomReady) out_ready = ($urandom_range(0, 99) >= 30);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] ch, input logic [11:0] code, input int gap);
    adc_valid   = 1'b1;
    adc_channel = ch;
    adc_data    = code;
    tick();
    adc_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    monEn   = 1'b0;
    expQ.delete();
    tick();
    tick();
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_flags", 32'({out_sop, out_eop}), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    monEn   = 1'b1;
  endtask

  task automatic queueWindow(input int base);
    for (int k = 0; k < WinLen; k++) begin
      expQ.push_back({(k == 0), (k == WinLen - 1), sampleVal[base + k]});
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (expQ.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(expQ.size()), 32'd0);
    repeat (20) tick();
  endtask

  task automatic loadRamp();
    for (int i = 0; i < 32; i++) sampleVal[i] = 16'(i);
  endtask

  initial begin
    tick();

    // Plain ramp, one sample every six cycles.
    resetDut();
    loadRamp();
    queueWindow(0);
    queueWindow(4);
    queueWindow(8);
    for (int i = 0; i < 16; i++) applyStimulus(5'd1, 12'(2048 + i), 5);
    drain("t1_drain");
    checkOutput("t1_overrun", 32'(overrun), 32'd0);

    // Ramp on channel 1 surrounded by full-scale codes on channels 0 and 2.
    resetDut();
    queueWindow(0);
    queueWindow(4);
    queueWindow(8);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(5'd0, 12'd4095, 1);
      applyStimulus(5'd1, 12'(2048 + i), 1);
      applyStimulus(5'd2, 12'd4095, 1);
    end
    drain("t2_drain");

    // Conversion corner codes, plus one matching sample presented while disabled.
    resetDut();
    for (int i = 0; i < 8; i++) sampleVal[i] = t3Exp[i];
    queueWindow(0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(5'd1, t3Code[i], 1);
      if (i == 3) begin
        enable = 1'b0;
        applyStimulus(5'd1, 12'd4095, 1);
        enable = 1'b1;
      end
    end
    drain("t3_drain");

    // Ramp with random backpressure.
    resetDut();
    loadRamp();
    queueWindow(0);
    queueWindow(4);
    queueWindow(8);
    randomReady = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus(5'd1, 12'(2048 + i), 5);
    drain("t4_drain");
    randomReady = 1'b0;
    tick();
    out_ready = 1'b1;
    checkOutput("t4_overrun", 32'(overrun), 32'd0);

    // Downstream blocked: pending slot fills, a trigger is lost, then samples drop.
    resetDut();
    out_ready = 1'b0;
    queueWindow(0);
    queueWindow(4);
    for (int i = 0; i < 15; i++) applyStimulus(5'd1, 12'(2048 + i), 0);
    checkOutput("t5_no_ovr", 32'(overrun), 32'd0);
    applyStimulus(5'd1, 12'(2048 + 15), 0);
    checkOutput("t5_trig_lost", 32'(overrun), 32'd1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    checkOutput("t5_clear", 32'(overrun), 32'd0);
    clear_overrun = 1'b1;
    applyStimulus(5'd1, 12'(2048 + 16), 0);
    clear_overrun = 1'b0;
    checkOutput("t5_set_wins", 32'(overrun), 32'd1);
    for (int i = 17; i < 20; i++) applyStimulus(5'd1, 12'(2048 + i), 0);
    checkOutput("t5_overrun", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    drain("t5_drain");
    checkOutput("t5_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of a window, then a full refill is needed.
    begin
      logic found;
      found = 1'b0;
      resetDut();
      queueWindow(0);
      for (int i = 0; i < 8; i++) applyStimulus(5'd1, 12'(2048 + i), (i < 7) ? 5 : 0);
      for (int n = 0; n < 50 && !found; n++) begin
        if (out_valid && out_data == 16'd3) found = 1'b1;
        else tick();
      end
      checkOutput("t6_beat3_seen", 32'(found), 32'd1);
      reset_n = 1'b0;
      monEn   = 1'b0;
      expQ.delete();
      tick();
      checkOutput("t6_valid", 32'(out_valid), 32'd0);
      checkOutput("t6_overrun", 32'(overrun), 32'd0);
      checkOutput("t6_flags", 32'({out_sop, out_eop}), 32'd0);
      reset_n = 1'b1;
      monEn   = 1'b1;
      for (int i = 0; i < 7; i++) applyStimulus(5'd1, 12'(2148 + i), 5);
      repeat (10) tick();
      for (int i = 0; i < 8; i++) sampleVal[i] = 16'(100 + i);
      queueWindow(0);
      applyStimulus(5'd1, 12'(2148 + 7), 0);
      drain("t6_drain");
    end

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
